// File: rtl/mfp_uart_loader_pkg.sv
// Shared constants for the UART loader: FSM states, error codes, sync byte and field lengths.
package mfp_uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_COUNT,
    ST_DATA,
    ST_WRITE,
    ST_CSUM
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  localparam int ADDR_BYTES  = 4;
  localparam int COUNT_BYTES = 2;
  localparam int WORD_BYTES  = 4;

endpackage

// File: rtl/mfp_uart_loader_timeout.sv
// Reloadable inter-byte timeout down-counter; expired fires on the edge where the count reaches zero.
module mfp_uart_loader_timeout
  import mfp_uart_loader_pkg::*;
#(
  parameter int unsigned timeout_cycles = 5000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic freeze,
  output logic expired
);

  localparam int unsigned width = $clog2(timeout_cycles + 1);
  localparam logic [width-1:0] reload_value = width'(timeout_cycles);
  localparam logic [width-1:0] one_value    = width'(1);

  logic [width-1:0] count_q, count_d;

  // NOTE: count_d gets its default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = reload_value;
    end else if (!freeze && count_q != '0) begin
      count_d = count_q - one_value;
    end
  end

  // A load in the same cycle means a byte arrived, and the byte wins over expiry.
  assign expired = !load && !freeze && (count_q == one_value);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mfp_uart_loader_ctrl.sv
// UART byte-stream load-protocol parser issuing 32-bit memory writes.
// Define MFP_UART_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module mfp_uart_loader_ctrl
  import mfp_uart_loader_pkg::*;
#(
  parameter int unsigned timeout_cycles = 5000000,
  parameter logic [7:0]  sync_byte      = DEFAULT_SYNC_BYTE
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  byte_data,
  input  logic        byte_ready,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  error_code
);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_req_q, wr_req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [1:0]  error_code_q, error_code_d;
  logic [7:0]  skid_q, skid_d;
  logic        skid_v_q, skid_v_d;
`ifdef MFP_UART_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        in_valid;
  logic [7:0]  in_byte;
  logic        tmo_load;
  logic        tmo_expired;

  mfp_uart_loader_timeout #(
    .timeout_cycles(timeout_cycles)
  ) u_timeout (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (tmo_load),
    .freeze (state_q == ST_WRITE),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_req_d     = wr_req_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    error_code_d = error_code_q;
    skid_d       = skid_q;
    skid_v_d     = skid_v_q;
`ifdef MFP_UART_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    // A byte parked during WRITE is older than any byte arriving now, so it goes first.
    in_valid = skid_v_q || byte_ready;
    in_byte  = skid_v_q ? skid_q : byte_data;
    tmo_load = byte_ready && (state_q != ST_IDLE || byte_data == sync_byte);

    case (state_q)
      ST_IDLE: begin
        skid_v_d = 1'b0;
        if (byte_ready && byte_data == sync_byte) begin
          state_d = ST_ADDR;
          busy_d  = 1'b1;
          idx_d   = '0;
`ifdef MFP_UART_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      ST_WRITE: begin
        if (byte_ready && skid_v_q) begin
          state_d      = ST_IDLE;
          wr_req_d     = 1'b0;
          busy_d       = 1'b0;
          error_d      = 1'b1;
          error_code_d = ERR_OVERRUN;
          skid_v_d     = 1'b0;
        end else begin
          if (byte_ready) begin
            skid_d   = byte_data;
            skid_v_d = 1'b1;
          end
          if (wr_ack) begin
            wr_req_d  = 1'b0;
            wr_addr_d = wr_addr_q + 32'd4;
            cnt_d     = cnt_q - 16'd1;
            if (cnt_d != 16'd0) begin
              state_d = ST_DATA;
            end else begin
`ifdef MFP_UART_LOADER_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
`endif
            end
          end
        end
      end

      default: begin
        // Draining the skid register while a new byte lands keeps the new one parked.
        if (skid_v_q) begin
          skid_d   = byte_data;
          skid_v_d = byte_ready;
        end
        if (in_valid) begin
`ifdef MFP_UART_LOADER_CHECKSUM_EN
          if (state_q != ST_CSUM) csum_d = csum_q ^ in_byte;
`endif
          case (state_q)
            ST_ADDR: begin
              wr_addr_d = {in_byte, wr_addr_q[31:8]};
              idx_d     = idx_q + 2'd1;
              if (idx_q == 2'(ADDR_BYTES - 1)) begin
                wr_addr_d[1:0] = 2'b00;
                idx_d          = '0;
                state_d        = ST_COUNT;
              end
            end
            ST_COUNT: begin
              cnt_d = {in_byte, cnt_q[15:8]};
              idx_d = idx_q + 2'd1;
              if (idx_q == 2'(COUNT_BYTES - 1)) begin
                idx_d = '0;
                if (cnt_d != 16'd0) begin
                  state_d = ST_DATA;
                end else begin
`ifdef MFP_UART_LOADER_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
`endif
                end
              end
            end
            ST_DATA: begin
              wr_data_d = {in_byte, wr_data_q[31:8]};
              idx_d     = idx_q + 2'd1;
              if (idx_q == 2'(WORD_BYTES - 1)) begin
                idx_d    = '0;
                wr_req_d = 1'b1;
                state_d  = ST_WRITE;
              end
            end
`ifdef MFP_UART_LOADER_CHECKSUM_EN
            ST_CSUM: begin
              state_d  = ST_IDLE;
              busy_d   = 1'b0;
              skid_v_d = 1'b0;
              if (in_byte == csum_q) begin
                done_d = 1'b1;
              end else begin
                error_d      = 1'b1;
                error_code_d = ERR_CSUM;
              end
            end
`endif
            default: state_d = ST_IDLE;
          endcase
        end else if (tmo_expired) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          error_d      = 1'b1;
          error_code_d = ERR_TIMEOUT;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      error_code_q <= ERR_NONE;
      skid_q       <= '0;
      skid_v_q     <= 1'b0;
`ifdef MFP_UART_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_req_q     <= wr_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      error_code_q <= error_code_d;
      skid_q       <= skid_d;
      skid_v_q     <= skid_v_d;
`ifdef MFP_UART_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign error_code = error_code_q;

endmodule

// File: tb/tb_mfp_uart_loader_ctrl.sv
// Self-checking bench for mfp_uart_loader_ctrl: directed protocol cases plus random frames
// compared against a frame-level reference model.
module tb_mfp_uart_loader_ctrl;

  localparam int unsigned TMO  = 100;
  localparam logic [7:0]  SYNC = 8'hA5;
`ifdef MFP_UART_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef logic [7:0] byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready = 1'b0;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack = 1'b0;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  error_code;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          n_err = 0;
  logic [1:0]  last_code = '0;
  int          ack_delay = 1;
  int          req_age = 0;
  logic [63:0] got_q[$];

  always #5 clock = ~clock;

  mfp_uart_loader_ctrl #(
    .timeout_cycles(TMO),
    .sync_byte     (SYNC)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .error_code(error_code)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Memory-side responder and event recorder, all sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      wr_ack  = 1'b0;
      req_age = 0;
    end else begin
      if (done) n_done++;
      if (error) begin
        n_err++;
        last_code = error_code;
      end
      if (wr_ack) begin
        wr_ack  = 1'b0;
        req_age = 0;
      end else if (wr_req) begin
        if (req_age >= ack_delay) begin
          wr_ack = 1'b1;
          got_q.push_back({wr_addr, wr_data});
        end
        req_age++;
      end else begin
        req_age = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    byte_data  = b;
    byte_ready = 1'b1;
    @(negedge clock);
    byte_ready = 1'b0;
  endtask

  task automatic clear_stats();
    @(negedge clock);
    #1;
    n_done = 0;
    n_err  = 0;
    got_q.delete();
  endtask

  // Everything after the sync byte except the checksum, little-endian fields.
  function automatic byte_q_t frame_body(input logic [31:0] addr, input word_q_t words);
    byte_q_t bs;
    logic [15:0] cnt;
    cnt = 16'(words.size());
    for (int b = 0; b < 4; b++) bs.push_back(addr[8*b +: 8]);
    for (int b = 0; b < 2; b++) bs.push_back(cnt[8*b +: 8]);
    foreach (words[i]) for (int b = 0; b < 4; b++) bs.push_back(words[i][8*b +: 8]);
    return bs;
  endfunction

  function automatic logic [7:0] xor_of(input byte_q_t bs);
    logic [7:0] x = '0;
    foreach (bs[i]) x ^= bs[i];
    return x;
  endfunction

  task automatic run_frame(input logic [31:0] addr, input word_q_t words, input bit bad_csum);
    byte_q_t     body;
    bit          exp_ok;
    logic [31:0] exp_addr;
    body = frame_body(addr, words);
    exp_ok = !(CSUM_EN && bad_csum);
    clear_stats();
    send_byte(SYNC);
    foreach (body[i]) send_byte(body[i]);
    if (CSUM_EN) send_byte(xor_of(body) ^ {7'd0, bad_csum});
    repeat (10) @(negedge clock);
    check("n_writes", 64'(got_q.size()), 64'(words.size()));
    exp_addr = addr & 32'hFFFF_FFFC;
    foreach (words[i]) begin
      if (i < got_q.size()) begin
        check("wr_addr", {32'd0, got_q[i][63:32]}, {32'd0, exp_addr});
        check("wr_data", {32'd0, got_q[i][31:0]}, {32'd0, words[i]});
      end
      exp_addr = exp_addr + 32'd4;
    end
    check("done_count", 64'(n_done), exp_ok ? 64'd1 : 64'd0);
    check("error_count", 64'(n_err), exp_ok ? 64'd0 : 64'd1);
    if (!exp_ok) check("csum_code", {62'd0, last_code}, 64'd1);
    check("busy_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    word_q_t words;
    byte_q_t body;
    int      k;

    repeat (3) @(negedge clock);
    check("rst_wr_req", {63'd0, wr_req}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_wr_addr", {32'd0, wr_addr}, 64'd0);
    check("rst_wr_data", {32'd0, wr_data}, 64'd0);
    check("rst_error_code", {62'd0, error_code}, 64'd0);
    reset_n = 1'b1;

    // Reference frame: two words at 0x1000, good then corrupted checksum.
    ack_delay = 1;
    words.delete();
    words.push_back(32'h4433_2211);
    words.push_back(32'h8877_6655);
    run_frame(32'h0000_1000, words, 1'b0);
    check("ref_write0", (got_q.size() > 0) ? got_q[0] : 64'd0, {32'h0000_1000, 32'h4433_2211});
    check("ref_write1", (got_q.size() > 1) ? got_q[1] : 64'd0, {32'h0000_1004, 32'h8877_6655});
    run_frame(32'h0000_1000, words, 1'b1);

    // Junk before sync is ignored; then an empty frame completes.
    clear_stats();
    send_byte(8'h00);
    check("junk_busy0", {63'd0, busy}, 64'd0);
    send_byte(8'hFF);
    check("junk_busy1", {63'd0, busy}, 64'd0);
    send_byte(8'h5A);
    check("junk_busy2", {63'd0, busy}, 64'd0);
    send_byte(SYNC);
    check("sync_busy", {63'd0, busy}, 64'd1);
    words.delete();
    body = frame_body(32'h2000_0040, words);
    foreach (body[i]) send_byte(body[i]);
    if (CSUM_EN) send_byte(xor_of(body));
    check("empty_done", {63'd0, done}, 64'd1);
    check("empty_busy", {63'd0, busy}, 64'd0);
    repeat (4) @(negedge clock);
    check("empty_writes", 64'(got_q.size()), 64'd0);

    // Stall after three address bytes.
    clear_stats();
    send_byte(SYNC);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    k = 0;
    while (!error && k < 300) begin
      @(negedge clock);
      k++;
    end
    check("tmo_cycles", 64'(k), 64'(TMO));
    check("tmo_code", {62'd0, error_code}, 64'd2);
    check("tmo_busy", {63'd0, busy}, 64'd0);

    // Two bytes arrive while the write is held off.
    ack_delay = 50;
    clear_stats();
    send_byte(SYNC);
    words.delete();
    words.push_back(32'hCAFE_F00D);
    body = frame_body(32'h0000_0100, words);
    foreach (body[i]) send_byte(body[i]);
    check("ovr_req_up", {63'd0, wr_req}, 64'd1);
    send_byte(8'h3C);
    check("ovr_skid_req", {63'd0, wr_req}, 64'd1);
    check("ovr_no_err_yet", {63'd0, error}, 64'd0);
    send_byte(8'hC3);
    check("ovr_error", {63'd0, error}, 64'd1);
    check("ovr_code", {62'd0, error_code}, 64'd3);
    check("ovr_req_drop", {63'd0, wr_req}, 64'd0);
    check("ovr_busy", {63'd0, busy}, 64'd0);
    ack_delay = 1;
    repeat (5) @(negedge clock);

    // Random frames against the model.
    for (int f = 0; f < 20; f++) begin
      logic [31:0] addr;
      bit          bad;
      logic [7:0]  junk;
      words.delete();
      for (int w = $urandom_range(0, 4); w > 0; w--) words.push_back($urandom);
      addr      = $urandom;
      bad       = CSUM_EN && ($urandom_range(0, 1) == 1);
      ack_delay = $urandom_range(0, 2);
      junk      = 8'($urandom);
      if (junk == SYNC) junk = junk ^ 8'h01;
      send_byte(junk);
      run_frame(addr, words, bad);
    end

    // Address wrap, then reset in the middle of the second write.
    ack_delay = 1;
    clear_stats();
    send_byte(SYNC);
    words.delete();
    words.push_back(32'h0102_0304);
    words.push_back(32'h0506_0708);
    body = frame_body(32'hFFFF_FFFF, words);
    for (int i = 0; i < 10; i++) send_byte(body[i]);
    k = 0;
    while (!wr_req && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("wrap_req0", {63'd0, wr_req}, 64'd1);
    check("wrap_addr0", {32'd0, wr_addr}, {32'd0, 32'hFFFF_FFFC});
    k = 0;
    while (wr_req && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("wrap_ack0", {63'd0, wr_req}, 64'd0);
    ack_delay = 1000;
    for (int i = 10; i < 14; i++) send_byte(body[i]);
    check("wrap_req1", {63'd0, wr_req}, 64'd1);
    check("wrap_addr1", {32'd0, wr_addr}, 64'd0);
    check("wrap_data1", {32'd0, wr_data}, {32'd0, 32'h0506_0708});
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_req", {63'd0, wr_req}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    @(negedge clock);
    reset_n   = 1'b1;
    ack_delay = 1;
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
